// File: rtl/fb_rect_writer_pkg.sv
// rtl/fb_rect_writer_pkg.sv - shared frame-buffer sizes and rectangle-writer FSM encodings
package fb_rect_writer_pkg;

  localparam int unsigned FB_W_DEF        = 320;
  localparam int unsigned FB_H_DEF        = 240;
  localparam int unsigned DISP_ADDR_WIDTH = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fb_rect_writer_if.sv
// rtl/fb_rect_writer_if.sv - rectangle command handshake and frame-buffer write port bundle
interface fb_rect_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [8:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [8:0]        cmd_w;
  logic [7:0]        cmd_h;
  logic [11:0]       cmd_color;
  logic [ADDR_W-1:0] fb_write_addr;
  logic [11:0]       fb_write_data;
  logic              fb_write_en;
  logic              busy;
  logic              done;
  logic              cmd_err;

  // Command source / frame-buffer observer side
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, fb_write_addr, fb_write_data, fb_write_en, busy, done, cmd_err
  );

  // Rectangle writer side
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, fb_write_addr, fb_write_data, fb_write_en, busy, done, cmd_err
  );
endinterface

// File: rtl/fb_addr_cursor.sv
// rtl/fb_addr_cursor.sv - pixel cursor: column/row counters, row base address and last-pixel detect
module fb_addr_cursor #(
  parameter int unsigned FB_W   = 320,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [8:0]        load_x,
  input  logic [7:0]        load_y,
  input  logic [8:0]        x0,
  input  logic [8:0]        w_eff,
  input  logic [7:0]        h_eff,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [8:0]        x_cur_q, x_cur_d;
  logic [8:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              end_of_row;

  assign end_of_row = (col_q == w_eff - 9'd1);
  assign last       = end_of_row && (row_q == h_eff - 8'd1);
  assign addr       = row_base_q + ADDR_W'(x_cur_q);

  // Next cursor position: load the top-left corner, or advance row-major
  always_comb begin
    x_cur_d    = x_cur_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (load) begin
      x_cur_d    = load_x;
      col_d      = 9'd0;
      row_d      = 8'd0;
      // y*320 as two shifts, no multiplier
      row_base_d = (ADDR_W'(load_y) << 8) + (ADDR_W'(load_y) << 6);
    end else if (step) begin
      if (end_of_row) begin
        x_cur_d    = x0;
        col_d      = 9'd0;
        row_d      = row_q + 8'd1;
        row_base_d = row_base_q + ADDR_W'(FB_W);
      end else begin
        x_cur_d = x_cur_q + 9'd1;
        col_d   = col_q + 9'd1;
      end
    end
  end

  // Cursor state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cur_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      x_cur_q    <= x_cur_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - rectangle-fill command engine for the 320x240 RGB444 frame buffer write port
// Optional clipping of partially off-screen rectangles: define FB_RECT_CLIP_EN.
module fb_rect_writer
  import fb_rect_writer_pkg::*;
#(
  parameter int unsigned FB_W   = FB_W_DEF,
  parameter int unsigned FB_H   = FB_H_DEF,
  parameter int unsigned ADDR_W = DISP_ADDR_WIDTH
) (
  input  logic    clk,
  input  logic    reset_n,
  fb_rect_if.slave bus
);

  state_e            state_q;
  logic [8:0]        x0_q, w_q;
  logic [7:0]        y_q, h_q;
  logic [11:0]       color_q;
  logic              cmd_ready_q, busy_q, we_q, done_q, err_q, last_issued_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       data_q;

  logic [9:0]        x_end;
  logic [8:0]        y_end;
  logic              empty, x_over, y_over, reject;
  logic [8:0]        w_eff;
  logic [7:0]        h_eff;
  logic              accept, issue;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_last;

  // Extents are widened by one bit so x+w and y+h cannot overflow
  assign x_end  = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end  = {1'b0, y_q} + {1'b0, h_q};
  assign empty  = (w_q == 9'd0) || (h_q == 8'd0) || (x0_q >= 9'(FB_W)) || (y_q >= 8'(FB_H));
  assign x_over = x_end > 10'(FB_W);
  assign y_over = y_end > 9'(FB_H);

`ifdef FB_RECT_CLIP_EN
  assign w_eff  = x_over ? (9'(FB_W) - x0_q) : w_q;
  assign h_eff  = y_over ? (8'(FB_H) - y_q) : h_q;
  assign reject = 1'b0;
`else
  assign w_eff  = w_q;
  assign h_eff  = h_q;
  assign reject = !empty && (x_over || y_over);
`endif

  assign accept = bus.cmd_valid && cmd_ready_q;
  // A pixel is handed to the write port on every SETUP->FILL edge and on each FILL edge until the last one
  assign issue  = ((state_q == ST_SETUP) && !empty && !reject) ||
                  ((state_q == ST_FILL) && !last_issued_q);

  fb_addr_cursor #(
    .FB_W   (FB_W),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    (issue),
    .load_x  (bus.cmd_x),
    .load_y  (bus.cmd_y),
    .x0      (x0_q),
    .w_eff   (w_eff),
    .h_eff   (h_eff),
    .addr    (cur_addr),
    .last    (cur_last)
  );

  // Command FSM with command latch and registered handshake/write outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      x0_q          <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      last_issued_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x0_q        <= bus.cmd_x;
            y_q         <= bus.cmd_y;
            w_q         <= bus.cmd_w;
            h_q         <= bus.cmd_h;
            color_q     <= bus.cmd_color;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (empty || reject) begin
            done_q  <= 1'b1;
            err_q   <= reject;
            state_q <= ST_DONE;
          end else begin
            we_q          <= 1'b1;
            addr_q        <= cur_addr;
            data_q        <= color_q;
            last_issued_q <= cur_last;
            state_q       <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last_issued_q) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            addr_q        <= cur_addr;
            last_issued_q <= cur_last;
          end
        end
        ST_DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.busy          = busy_q;
  assign bus.fb_write_en   = we_q;
  assign bus.fb_write_addr = addr_q;
  assign bus.fb_write_data = data_q;
  assign bus.done          = done_q;
  assign bus.cmd_err       = err_q;

endmodule
